prng_sched: RTL and testbench

Round-robin scheduler that shares one PRNG256 pseudo-random datapath among NREQ correlated-randomness requesters. It owns the per-requester block counters, drives the key/prefix/counter/Drdy inputs of the PRNG, tracks in-flight requests with a tag FIFO, and routes each 256-bit result back to its requester. It also sequences key changes: it stops issuing, drains the pipeline, then loads the new key.

---
 rtl/prng_sched_pkg.sv | 20 ++
 rtl/prng_tag_fifo.sv | 65 ++++++
 rtl/prng_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_prng_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prng_sched_pkg.sv
// prng_sched_pkg: types and constants shared by the PRNG scheduler slice.
//   cr_cnt_t       block counter type, shared with the PRNG256 datapath
//   sched_state_t  scheduler FSM encoding (RUN, DRAIN, LOAD)
//   PRNG_PREFIX_W  width of the per-requester domain prefix
package prng_sched_pkg;

  localparam int PRNG_PREFIX_W = 7;
  localparam int CR_CNT_W      = 8;
  localparam int KEY_W         = 128;
  localparam int BLK_W         = 256;

  typedef logic [CR_CNT_W-1:0] cr_cnt_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/prng_tag_fifo.sv
// prng_tag_fifo: synchronous FIFO holding the requester tag of every block
// in flight through the PRNG.
//   CLK        clock, rising edge
//   RST        asynchronous reset, active-high (empties the FIFO)
//   push       write push_data (ignored when full)
//   push_data  tag to store
//   pop        remove the head entry (ignored when empty)
//   pop_data   head entry, valid while !empty
//   empty      no entries stored
//   count      number of entries stored
// A push and a pop in the same cycle leave the occupancy unchanged.
module prng_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty    = (count == '0);
  assign do_push  = push && (count != (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prng_sched.sv
// prng_sched: round-robin scheduler sharing one PRNG256 datapath among NREQ
// requesters. Owns the per-requester block counters, issues key/prefix/
// counter blocks to the PRNG, tracks in-flight blocks with a tag FIFO and
// routes each 256-bit result back to its owner. Key changes stop issue,
// drain the PRNG pipeline, then load the new key.
//
// Parameters: NREQ (2..16) requesters, LATENCY = PRNG Drdy->Dvld cycles.
// Ports:
//   CLK, RST                 clock / asynchronous active-high reset
//   req, prefix              per-requester request level and 7-bit prefix
//   grant                    one-hot combinational grant
//   exhausted                requester counter used up under current key
//   key_in, key_wr, key_busy key change request and its busy flag
//   prng_key/prefix/cnt/drdy registered drive of the PRNG inputs
//   prng_dout, prng_dvld     PRNG result
//   rsp_vld, rsp_id, rsp_data routed result (no backpressure)
//   err                      sticky: PRNG result arrived with no tag
// Optional macro PRNG_SCHED_STATS_EN adds stat_cnt (NREQ x 32 saturating
// per-requester issue counters) and stat_clr (synchronous clear).
module prng_sched import prng_sched_pkg::*; #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 11
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*PRNG_PREFIX_W-1:0] prefix,
  output logic [NREQ-1:0]               grant,
  output logic [NREQ-1:0]               exhausted,
  input  logic [KEY_W-1:0]              key_in,
  input  logic                          key_wr,
  output logic                          key_busy,
  output logic [KEY_W-1:0]              prng_key,
  output logic [PRNG_PREFIX_W-1:0]      prng_prefix,
  output cr_cnt_t                       prng_cnt,
  output logic                          prng_drdy,
  input  logic [BLK_W-1:0]              prng_dout,
  input  logic                          prng_dvld,
  output logic                          rsp_vld,
  output logic [$clog2(NREQ)-1:0]       rsp_id,
  output logic [BLK_W-1:0]              rsp_data,
  output logic                          err
`ifdef PRNG_SCHED_STATS_EN
  ,
  output logic [NREQ*32-1:0]            stat_cnt,
  input  logic                          stat_clr
`endif
);

  localparam int IDW        = $clog2(NREQ);
  localparam int FIFO_DEPTH = 2 ** $clog2(LATENCY + 2);
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  sched_state_t     state_q;
  logic [KEY_W-1:0] shadow_q;
  cr_cnt_t          cnt_q [NREQ];
  logic [NREQ-1:0]  exh_q;
  logic [IDW-1:0]   start_q;

  logic [NREQ-1:0]  elig;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  int               idx;

  logic [IDW-1:0]   pop_tag;
  logic             fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic             pop_ok;

  logic                     drdy_p1;
  logic [PRNG_PREFIX_W-1:0] prefix_p1;
  cr_cnt_t                  cnt_p1;
  logic                     vld_p1;
  logic [IDW-1:0]           id_p1;
  logic [BLK_W-1:0]         data_p1;
  logic                     err_q;

  // Stage 0: eligibility and round-robin search from start_q. RST gates the
  // combinational grant so it reads zero for the whole reset period.
  always_comb begin
    elig = '0;
    if (!RST && state_q == RUN && fifo_count < CW'(FIFO_DEPTH)) begin
      elig = req & ~exh_q;
    end
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(start_q) + off) % NREQ;
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  // Key staging: any key_wr overwrites the shadow; it only reaches the PRNG
  // in LOAD, after the pipeline has drained.
  always_ff @(posedge CLK) begin
    if (key_wr) shadow_q <= key_in;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= RUN;
      key_busy <= 1'b0;
      prng_key <= '0;
      exh_q    <= '0;
      start_q  <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else begin
      if (grant_any) begin
        start_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);
        // Counters never wrap: the last value is issued once, then the
        // requester is locked out until the next key.
        if (&cnt_q[grant_idx]) exh_q[grant_idx] <= 1'b1;
        else                   cnt_q[grant_idx] <= cnt_q[grant_idx] + cr_cnt_t'(1);
      end
      unique case (state_q)
        RUN: begin
          if (key_wr) begin
            state_q  <= DRAIN;
            key_busy <= 1'b1;
          end
        end
        DRAIN: begin
          if (fifo_empty && !prng_dvld) state_q <= LOAD;
        end
        LOAD: begin
          prng_key <= shadow_q;
          exh_q    <= '0;
          for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
          key_busy <= 1'b0;
          state_q  <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  prng_tag_fifo #(
    .WIDTH (IDW),
    .DEPTH (FIFO_DEPTH)
  ) u_tag_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (grant_any),
    .push_data (grant_idx),
    .pop       (prng_dvld),
    .pop_data  (pop_tag),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign pop_ok = prng_dvld && !fifo_empty;

  // Stage 1: registered PRNG issue and registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drdy_p1   <= 1'b0;
      prefix_p1 <= '0;
      cnt_p1    <= '0;
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      data_p1   <= '0;
      err_q     <= 1'b0;
    end else begin
      drdy_p1 <= grant_any;
      if (grant_any) begin
        prefix_p1 <= prefix[grant_idx*PRNG_PREFIX_W +: PRNG_PREFIX_W];
        cnt_p1    <= cnt_q[grant_idx];
      end
      vld_p1 <= pop_ok;
      if (pop_ok) begin
        id_p1   <= pop_tag;
        data_p1 <= prng_dout;
      end
      if (prng_dvld && fifo_empty) err_q <= 1'b1;
    end
  end

  assign prng_drdy   = drdy_p1;
  assign prng_prefix = prefix_p1;
  assign prng_cnt    = cnt_p1;
  assign rsp_vld     = vld_p1;
  assign rsp_id      = id_p1;
  assign rsp_data    = data_p1;
  assign err         = err_q;
  assign exhausted   = exh_q;

`ifdef PRNG_SCHED_STATS_EN
  logic [31:0] stat_q [NREQ];

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Stat counters survive key changes; only RST and stat_clr clear them.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (grant_any) begin
      stat_q[grant_idx] <= sat_inc(stat_q[grant_idx]);
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat
    assign stat_cnt[g*32 +: 32] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_prng_sched.sv
module tb_prng_sched;
  import prng_sched_pkg::*;

  localparam int NREQ = 4;
  localparam int LAT  = 11;
  localparam int PAD  = BLK_W - KEY_W - PRNG_PREFIX_W - $bits(cr_cnt_t);

  localparam logic [127:0] KEY_A = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] KEY_B = 128'hdead_beef_cafe_f00d_1357_9bdf_2468_ace0;

  logic                          CLK = 1'b0;
  logic                          RST = 1'b1;
  logic [NREQ-1:0]               req = '0;
  logic [NREQ*PRNG_PREFIX_W-1:0] prefix;
  logic [NREQ-1:0]               grant;
  logic [NREQ-1:0]               exhausted;
  logic [127:0]                  key_in = '0;
  logic                          key_wr = 1'b0;
  logic                          key_busy;
  logic [127:0]                  prng_key;
  logic [PRNG_PREFIX_W-1:0]      prng_prefix;
  cr_cnt_t                       prng_cnt;
  logic                          prng_drdy;
  logic [255:0]                  prng_dout;
  logic                          prng_dvld;
  logic                          rsp_vld;
  logic [1:0]                    rsp_id;
  logic [255:0]                  rsp_data;
  logic                          err;
`ifdef PRNG_SCHED_STATS_EN
  logic [NREQ*32-1:0]            stat_cnt;
  logic                          stat_clr = 1'b0;
`endif

  prng_sched #(.NREQ(NREQ), .LATENCY(LAT)) dut (
    .CLK(CLK), .RST(RST), .req(req), .prefix(prefix), .grant(grant),
    .exhausted(exhausted), .key_in(key_in), .key_wr(key_wr),
    .key_busy(key_busy), .prng_key(prng_key), .prng_prefix(prng_prefix),
    .prng_cnt(prng_cnt), .prng_drdy(prng_drdy), .prng_dout(prng_dout),
    .prng_dvld(prng_dvld), .rsp_vld(rsp_vld), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .err(err)
`ifdef PRNG_SCHED_STATS_EN
    , .stat_cnt(stat_cnt), .stat_clr(stat_clr)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  // PRNG stand-in: fixed LAT-cycle pipe, output block tags key/prefix/cnt.
  logic         pv [LAT];
  logic [255:0] pd [LAT];
  logic         inj_dvld = 1'b0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) pv[i] <= 1'b0;
    end else begin
      pv[0] <= prng_drdy;
      pd[0] <= {prng_key, {PAD{1'b0}}, prng_prefix, prng_cnt};
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign prng_dvld = pv[LAT-1] | inj_dvld;
  assign prng_dout = inj_dvld ? {8{32'h5a5a_a5a5}} : pd[LAT-1];

  // Bench-side model state and scoreboard.
  typedef struct {
    int           id;
    logic [255:0] data;
    int           cyc;
  } exp_t;

  exp_t          sb_q [$];
  logic [6:0]    pfx [NREQ];
  cr_cnt_t       m_cnt [NREQ];
  logic [3:0]    m_exh = '0;
  logic [127:0]  cur_key = '0;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] exp_data(input int g, input cr_cnt_t c);
    return {cur_key, {PAD{1'b0}}, pfx[g], c};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREQ; i++) m_cnt[i] = '0;
    m_exh = '0;
  endtask

  // Monitor: pops one expectation per presented response.
  always @(negedge CLK) begin
    if (!RST && rsp_vld) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexpected: got id %0d want no response", rsp_id);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", 256'(rsp_id), 256'(e.id));
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_cycle", 256'(cyc), 256'(e.cyc));
      end
    end
  end

  // Called #1 after a negedge with req already driven: checks the grant,
  // records the expected response, then checks the registered issue.
  task automatic finish_issue(input int g);
    logic [3:0] eg;
    cr_cnt_t    ec;
    exp_t       e;
    eg = (g < 0) ? 4'b0000 : (4'b0001 << g);
    ec = '0;
    chk("grant", 256'(grant), 256'(eg));
    if (g >= 0) begin
      ec    = m_cnt[g];
      e.id   = g;
      e.data = exp_data(g, ec);
      e.cyc  = cyc + LAT + 2;
      sb_q.push_back(e);
      if (m_cnt[g] == '1) m_exh[g] = 1'b1;
      else                m_cnt[g] = m_cnt[g] + cr_cnt_t'(1);
    end
    @(posedge CLK);
    #1;
    chk("prng_drdy", 256'(prng_drdy), 256'(g >= 0));
    if (g >= 0) begin
      chk("prng_cnt", 256'(prng_cnt), 256'(ec));
      chk("prng_prefix", 256'(prng_prefix), 256'(pfx[g]));
    end
    chk("exhausted", 256'(exhausted), 256'(m_exh));
  endtask

  task automatic drive_issue(input logic [3:0] r, input int g);
    @(negedge CLK);
    req = r;
    #1;
    finish_issue(g);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk("drain_pending", 256'(sb_q.size()), 256'(0));
    repeat (2) @(negedge CLK);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_grant", 256'(grant), 256'(0));
    chk("rst_exhausted", 256'(exhausted), 256'(0));
    chk("rst_key_busy", 256'(key_busy), 256'(0));
    chk("rst_prng_key", 256'(prng_key), 256'(0));
    chk("rst_prng_prefix", 256'(prng_prefix), 256'(0));
    chk("rst_prng_cnt", 256'(prng_cnt), 256'(0));
    chk("rst_prng_drdy", 256'(prng_drdy), 256'(0));
    chk("rst_rsp_vld", 256'(rsp_vld), 256'(0));
    chk("rst_rsp_id", 256'(rsp_id), 256'(0));
    chk("rst_rsp_data", rsp_data, 256'(0));
    chk("rst_err", 256'(err), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  done;
    for (int i = 0; i < NREQ; i++) pfx[i] = 7'h10 + 7'(i);
    prefix = {pfx[3], pfx[2], pfx[1], pfx[0]};
    model_clear();

    // Reset state, with requests already pending.
    req = 4'hF;
    repeat (3) @(posedge CLK);
    #1;
    chk_reset_outputs();
    @(negedge CLK);
    req = '0;
    RST = 1'b0;

    // Round robin over all four requesters, twice.
    drive_issue(4'hF, 0);
    drive_issue(4'hF, 1);
    drive_issue(4'hF, 2);
    drive_issue(4'hF, 3);
    drive_issue(4'hF, 0);
    drive_issue(4'hF, 1);
    drive_issue(4'hF, 2);
    drive_issue(4'hF, 3);
    @(negedge CLK);
    req = '0;
    wait_drain();

    // Requester 2 alone until its counter runs out (last issue uses all-ones).
    n = 0;
    while (!m_exh[2] && n < 300) begin
      drive_issue(4'b0100, 2);
      n++;
    end
    chk("exh2_reached", 256'(m_exh[2]), 256'(1));
    drive_issue(4'b0100, -1);
    drive_issue(4'b0100, -1);
    chk("exh2_flag", 256'(exhausted), 256'(4'b0100));
    @(negedge CLK);
    req = '0;
    wait_drain();

    // Key change with five blocks in flight; requester 2 is still exhausted.
    drive_issue(4'hF, 3);
    drive_issue(4'hF, 0);
    drive_issue(4'hF, 1);
    drive_issue(4'hF, 3);
    drive_issue(4'hF, 0);
    @(negedge CLK);
    req    = '0;
    key_in = KEY_A;
    key_wr = 1'b1;
    #1;
    chk("key_busy_before", 256'(key_busy), 256'(0));
    @(negedge CLK);
    key_in = KEY_B;
    key_wr = 1'b1;
    req    = 4'hF;
    #1;
    chk("key_busy_drain", 256'(key_busy), 256'(1));
    chk("drain_grant0", 256'(grant), 256'(0));
    n    = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge CLK);
      key_wr = 1'b0;
      req    = 4'hF;
      #1;
      if (key_busy) begin
        chk("drain_grant", 256'(grant), 256'(0));
        chk("drain_old_key", 256'(prng_key), 256'(0));
        n++;
      end else begin
        done = 1'b1;
      end
    end
    chk("key_change_done", 256'(done), 256'(1));
    if (done) begin
      cur_key = KEY_B;
      model_clear();
      chk("new_key", 256'(prng_key), 256'(KEY_B));
      chk("inflight_delivered", 256'(sb_q.size()), 256'(0));
      chk("exh_cleared", 256'(exhausted), 256'(0));
      finish_issue(1);
    end
    @(negedge CLK);
    req = '0;
    wait_drain();

    // Result with no tag in flight.
    chk("err_idle", 256'(err), 256'(0));
    @(negedge CLK);
    inj_dvld = 1'b1;
    @(negedge CLK);
    inj_dvld = 1'b0;
    #1;
    chk("err_set", 256'(err), 256'(1));
    chk("err_no_rsp", 256'(rsp_vld), 256'(0));
    repeat (3) @(negedge CLK);
    #1;
    chk("err_sticky", 256'(err), 256'(1));

    // Asynchronous reset in the middle of a stream.
    drive_issue(4'hF, 2);
    drive_issue(4'hF, 3);
    drive_issue(4'hF, 0);
    #2;
    RST = 1'b1;
    #1;
    chk_reset_outputs();
    sb_q.delete();
    model_clear();
    cur_key = '0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    drive_issue(4'hF, 0);
    drive_issue(4'hF, 1);
    @(negedge CLK);
    req = '0;
    wait_drain();
    chk("err_after_reset", 256'(err), 256'(0));

`ifdef PRNG_SCHED_STATS_EN
    #2;
    RST = 1'b1;
    sb_q.delete();
    model_clear();
    cur_key = '0;
    repeat (2) @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("stat_reset", 256'(stat_cnt), 256'(0));
    for (int i = 0; i < 10; i++) drive_issue(4'b0010, 1);
    @(negedge CLK);
    req = '0;
    #1;
    chk("stat_req1", 256'(stat_cnt[63:32]), 256'(10));
    chk("stat_req0", 256'(stat_cnt[31:0]), 256'(0));
    wait_drain();
    stat_clr = 1'b1;
    @(negedge CLK);
    stat_clr = 1'b0;
    #1;
    chk("stat_clr", 256'(stat_cnt), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
